pwm_mc: RTL and testbench
=========================

PWM_MC -- requirements
Module: pwm_mc

Interface
REQ-001 Parameter WIDTH, default 11: counter and duty width in bits.
REQ-002 Parameter NCH, default 2: number of independent PWM channels.
REQ-003 Parameter DEAD, default 8: dead-time in clk cycles; 0 SHALL be legal.
REQ-004 Parameter MODE, default PWM_EDGE: counter mode, pwm_mode_e {PWM_EDGE, PWM_CENTER}.
REQ-005 clk  input  1  the block's only clock; all flops on posedge clk.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 duty  input  NCH x WIDTH  requested duty per channel.
REQ-008 duty_wr  input  1  single-cycle strobe capturing all duty channels into the pending register.
REQ-009 pend_vld  output  1  pending duty set captured but not yet applied.
REQ-010 period_start  output  1  high for one cycle while cnt==0.
REQ-011 pwm_hi  output  NCH  high-side drive per channel.
REQ-012 pwm_lo  output  NCH  low-side drive per channel.

Function
REQ-013 Shared counter cnt, WIDTH bits; MAX = 2^WIDTH-1.
REQ-014 PWM_EDGE: cnt SHALL increment by 1 and wrap MAX->0; period = 2^WIDTH cycles.
REQ-015 PWM_CENTER: cnt SHALL count 0 up to MAX, then down to 1, then 0; direction flips at MAX and at 0; period = 2*MAX cycles.
REQ-016 End-of-period cycle E: cnt==MAX (edge), or cnt==1 while counting down (center).
REQ-017 duty_wr SHALL load duty into pend[] and set pend_vld the next cycle; a second duty_wr before E SHALL overwrite pend[].
REQ-018 In cycle E with pend_vld set, act[] SHALL load pend[] and pend_vld SHALL clear, so the new duty governs the period starting at cnt==0.
REQ-019 duty_wr during E SHALL bypass pend: act[] loads duty directly and pend_vld stays/becomes 0.
REQ-020 act[] SHALL never change outside E; no mid-period duty change.
REQ-021 raw[i] SHALL be a flop of (cnt < act[i]), one-cycle latency from cnt.
REQ-022 act[i]==0 SHALL give raw[i]=0 permanently; in edge mode act[i]==MAX SHALL give raw high MAX of 2^WIDTH cycles.
REQ-023 Per channel, dead-time counter dt[i] SHALL clear on any raw[i] change and otherwise increment, saturating at DEAD.
REQ-024 pwm_hi[i] = raw[i] & (dt[i]==DEAD); pwm_lo[i] = ~raw[i] & (dt[i]==DEAD); both registered.
REQ-025 pwm_hi[i] and pwm_lo[i] SHALL never be high in the same cycle.
REQ-026 A raw level shorter than DEAD cycles SHALL produce no pulse on that output; both outputs stay low.
REQ-027 DEAD==0 SHALL give pwm_lo = ~pwm_hi with no gap.

Reset
REQ-028 Reset values: cnt=0, direction=up, act[]=0, pend[]=0, pend_vld=0, raw=0, dt=0, pwm_hi=0, pwm_lo=0, period_start=0.
REQ-029 Reset assertion mid-period SHALL force both drive outputs low in the same cycle, with no clock needed.
REQ-030 After release, pwm_lo SHALL rise only after DEAD full cycles.

Structure
REQ-031 Package pwm_pkg SHALL hold pwm_mode_e and the default WIDTH/DEAD constants.
REQ-032 Sub-module pwm_deadband, parameter DEAD, one instance per channel, input raw, outputs hi/lo, SHALL hold dt and the output flops.
REQ-033 Counter, E detection, pend/act registers and compare SHALL live in pwm_mc.

Verification (WIDTH=4, NCH=2, DEAD=2 unless stated)
REQ-034 Reset held, then released -> all outputs 0 during reset; pwm_lo=2'b11 from the 3rd cycle after release; pwm_hi=0.
REQ-035 Edge mode, duty ch0=5 applied -> per 16-cycle period raw high 5 cycles, pwm_hi high 3, pwm_lo high 9, never overlapping.
REQ-036 duty_wr ch0=5->9 at cnt==6 -> pend_vld=1 until E; duty 5 holds to cnt==15; duty 9 from next cnt==0.
REQ-037 duty_wr ch0=12 in cycle cnt==15 -> applied at next cnt==0; pend_vld stays 0.
REQ-038 Center mode, duty ch1=3 -> period 30 cycles; raw high 5 cycles, centred on cnt==0; period_start once per 30 cycles.
REQ-039 Edge mode, duty ch0=1, DEAD=2 -> pwm_hi never high; pwm_lo low exactly 3 cycles per period.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and defaults for the multi-channel PWM block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    localparam int PWM_WIDTH_DEF = 11;
    localparam int PWM_NCH_DEF   = 2;
    localparam int PWM_DEAD_DEF  = 8;

    // Dead-time counters saturate at DEAD, so they need room for 0..DEAD.
    function automatic int dt_bits(input int dead);
        return (dead < 1) ? 1 : $clog2(dead + 1);
    endfunction

endpackage

// File: rtl/pwm_deadband.sv
// Complementary gate-drive generator with dead-time insertion for one channel.
// Latency: hi/lo registered, one cycle after raw.
// Backpressure: none; a raw level shorter than DEAD cycles yields no pulse.
module pwm_deadband
    import pwm_pkg::*;
#(
    parameter int DEAD = PWM_DEAD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic hi,
    output logic lo
);

    localparam int             DW     = dt_bits(DEAD);
    localparam logic [DW-1:0]  DT_MAX = DW'(DEAD);

    logic          raw_q;
    logic [DW-1:0] dt;
    logic [DW-1:0] dt_nxt;
    logic          settled;

    always_comb begin
        dt_nxt = dt;
        if (raw != raw_q) begin
            dt_nxt = '0;
        end else if (dt != DT_MAX) begin
            dt_nxt = dt + DW'(1);
        end
    end

    // With DEAD==0 the counter is pinned at zero, so lo is simply ~raw.
    assign settled = (dt_nxt == DT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw_q <= 1'b0;
            dt    <= '0;
            hi    <= 1'b0;
            lo    <= 1'b0;
        end else begin
            raw_q <= raw;
            dt    <= dt_nxt;
            hi    <= raw & settled;
            lo    <= ~raw & settled;
        end
    end

    a_no_shoot_through: assert property (@(posedge clk) disable iff (!rst_n) !(hi && lo));

endmodule

// File: rtl/pwm_mc.sv
// Multi-channel PWM: shared edge/center counter, double-buffered duty, dead-time drive.
// Latency: raw one cycle after cnt, pwm_hi/pwm_lo two cycles after cnt.
// Backpressure: none; duty_wr always accepted, a later write overwrites the pending set.
module pwm_mc
    import pwm_pkg::*;
#(
    parameter int        WIDTH = PWM_WIDTH_DEF,
    parameter int        NCH   = PWM_NCH_DEF,
    parameter int        DEAD  = PWM_DEAD_DEF,
    parameter pwm_mode_e MODE  = PWM_EDGE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NCH-1:0][WIDTH-1:0]  duty,
    input  logic                       duty_wr,
    output logic                       pend_vld,
    output logic                       period_start,
    output logic [NCH-1:0]             pwm_hi,
    output logic [NCH-1:0]             pwm_lo
);

    localparam logic [WIDTH-1:0] MAX = '1;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0]            cnt;
    logic [WIDTH-1:0]            cnt_nxt;
    logic                        dir_down;
    logic                        dir_nxt;
    logic                        eop;
    logic [NCH-1:0][WIDTH-1:0]   pend;
    logic [NCH-1:0][WIDTH-1:0]   act;
    logic [NCH-1:0]              raw;

    always_comb begin
        cnt_nxt = cnt + ONE;
        dir_nxt = dir_down;
        if (MODE == PWM_CENTER) begin
            if (!dir_down) begin
                if (cnt == MAX) begin
                    cnt_nxt = MAX - ONE;
                    dir_nxt = 1'b1;
                end
            end else begin
                cnt_nxt = cnt - ONE;
                if (cnt == ONE) begin
                    dir_nxt = 1'b0;
                end
            end
        end
    end

    // Last cycle of a period: the only point where act may be updated.
    assign eop = (MODE == PWM_CENTER) ? (dir_down && (cnt == ONE)) : (cnt == MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            dir_down     <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            dir_down     <= dir_nxt;
            period_start <= (cnt_nxt == '0);
        end
    end

    // A write landing in the end-of-period cycle goes straight to act.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= '0;
            act      <= '0;
            pend_vld <= 1'b0;
        end else if (duty_wr && eop) begin
            act      <= duty;
            pend_vld <= 1'b0;
        end else begin
            if (eop && pend_vld) begin
                act      <= pend;
                pend_vld <= 1'b0;
            end
            if (duty_wr) begin
                pend     <= duty;
                pend_vld <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                raw[i] <= (cnt < act[i]);
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pwm_deadband #(
            .DEAD (DEAD)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw[g]),
            .hi    (pwm_hi[g]),
            .lo    (pwm_lo[g])
        );
    end

    a_act_only_at_eop: assert property (@(posedge clk) disable iff (!rst_n) !eop |=> $stable(act));

endmodule

// File: tb/tb_pwm_mc.sv
// Bench for pwm_mc: edge (DEAD=2 and DEAD=0) and center instances, WIDTH=4, NCH=2.
// Per-period high counts of pwm_hi/pwm_lo are scored against hand-computed expectations.
module tb_pwm_mc;
    import pwm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [1:0][3:0] duty_e, duty_c;
    logic            duty_wr_e, duty_wr_c;
    logic            pend_e, ps_e, pend_c, ps_c, pend_z, ps_z;
    logic [1:0]      hi_e, lo_e, hi_c, lo_c, hi_z, lo_z;

    pwm_mc #(.WIDTH(4), .NCH(2), .DEAD(2), .MODE(PWM_EDGE)) u_e (
        .clk(clk), .rst_n(rst_n), .duty(duty_e), .duty_wr(duty_wr_e),
        .pend_vld(pend_e), .period_start(ps_e), .pwm_hi(hi_e), .pwm_lo(lo_e));

    pwm_mc #(.WIDTH(4), .NCH(2), .DEAD(0), .MODE(PWM_EDGE)) u_z (
        .clk(clk), .rst_n(rst_n), .duty(duty_e), .duty_wr(duty_wr_e),
        .pend_vld(pend_z), .period_start(ps_z), .pwm_hi(hi_z), .pwm_lo(lo_z));

    pwm_mc #(.WIDTH(4), .NCH(2), .DEAD(2), .MODE(PWM_CENTER)) u_c (
        .clk(clk), .rst_n(rst_n), .duty(duty_c), .duty_wr(duty_wr_c),
        .pend_vld(pend_c), .period_start(ps_c), .pwm_hi(hi_c), .pwm_lo(lo_c));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        int idx;
        int hi0, lo0, hi1, lo1;
        int zhi0, zlo0;
        int len;
    } exp_t;

    exp_t q_e[$];
    exp_t q_c[$];

    // Window counters, index 0 = edge instance, 1 = center instance.
    int per_idx[2], widx[2];
    bit h1[2], h2[2], wopen[2];
    int c_hi0[2], c_lo0[2], c_hi1[2], c_lo1[2], c_len[2], c_ovl[2];
    int c_zhi0, c_zlo0, c_gap;

    task automatic push_e(input int idx, input int hi0, input int lo0, input int hi1,
                          input int lo1, input int zhi0, input int zlo0);
        exp_t e;
        e.idx = idx; e.hi0 = hi0; e.lo0 = lo0; e.hi1 = hi1; e.lo1 = lo1;
        e.zhi0 = zhi0; e.zlo0 = zlo0; e.len = 16;
        q_e.push_back(e);
    endtask

    task automatic push_c(input int idx, input int hi0, input int lo0, input int hi1, input int lo1);
        exp_t e;
        e.idx = idx; e.hi0 = hi0; e.lo0 = lo0; e.hi1 = hi1; e.lo1 = lo1;
        e.zhi0 = -1; e.zlo0 = -1; e.len = 30;
        q_c.push_back(e);
    endtask

    task automatic close_win(input int d);
        exp_t  e;
        bit    found;
        string p;
        found = 1'b0;
        p = $sformatf("%s_w%0d", (d == 0) ? "edge" : "ctr", widx[d]);
        if (d == 0) begin
            while (q_e.size() > 0 && q_e[0].idx < widx[d]) begin
                checks++; errors++;
                $display("FAIL edge_window_missed: got window %0d expected %0d", widx[d], q_e[0].idx);
                void'(q_e.pop_front());
            end
            if (q_e.size() > 0 && q_e[0].idx == widx[d]) begin
                e = q_e.pop_front(); found = 1'b1;
            end
        end else begin
            while (q_c.size() > 0 && q_c[0].idx < widx[d]) begin
                checks++; errors++;
                $display("FAIL ctr_window_missed: got window %0d expected %0d", widx[d], q_c[0].idx);
                void'(q_c.pop_front());
            end
            if (q_c.size() > 0 && q_c[0].idx == widx[d]) begin
                e = q_c.pop_front(); found = 1'b1;
            end
        end
        if (found) begin
            chk({p, "_len"}, c_len[d], e.len);
            chk({p, "_hi0"}, c_hi0[d], e.hi0);
            chk({p, "_lo0"}, c_lo0[d], e.lo0);
            chk({p, "_hi1"}, c_hi1[d], e.hi1);
            chk({p, "_lo1"}, c_lo1[d], e.lo1);
            chk({p, "_overlap"}, c_ovl[d], 0);
            if (e.zhi0 >= 0) begin
                chk({p, "_dead0_hi0"}, c_zhi0, e.zhi0);
                chk({p, "_dead0_lo0"}, c_zlo0, e.zlo0);
                chk({p, "_dead0_gap"}, c_gap, 0);
            end
        end
    endtask

    // Outputs at a negedge reflect cnt from two cycles earlier, so each window
    // opens two negedges after period_start and spans exactly one counter period.
    always @(negedge clk) begin : monitor
        logic       psv;
        logic [1:0] hh, ll;
        for (int d = 0; d < 2; d++) begin
            psv = (d == 0) ? ps_e : ps_c;
            hh  = (d == 0) ? hi_e : hi_c;
            ll  = (d == 0) ? lo_e : lo_c;
            if (!rst_n) begin
                wopen[d] = 1'b0; h1[d] = 1'b0; h2[d] = 1'b0;
            end else begin
                if (h2[d]) begin
                    if (wopen[d]) close_win(d);
                    wopen[d] = 1'b1;
                    widx[d]  = per_idx[d];
                    c_hi0[d] = 0; c_lo0[d] = 0; c_hi1[d] = 0; c_lo1[d] = 0;
                    c_len[d] = 0; c_ovl[d] = 0;
                    if (d == 0) begin
                        c_zhi0 = 0; c_zlo0 = 0; c_gap = 0;
                    end
                end
                if (wopen[d]) begin
                    c_len[d]++;
                    c_hi0[d] += int'(hh[0]); c_lo0[d] += int'(ll[0]);
                    c_hi1[d] += int'(hh[1]); c_lo1[d] += int'(ll[1]);
                    if ((hh & ll) != 2'b00) c_ovl[d]++;
                    if (d == 0) begin
                        c_zhi0 += int'(hi_z[0]); c_zlo0 += int'(lo_z[0]);
                        if (lo_z != ~hi_z) c_gap++;
                    end
                end
                h2[d] = h1[d];
                h1[d] = psv;
                if (psv) per_idx[d]++;
            end
        end
    end

    task automatic wait_ps(input int d, output int idx);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #1;
            if ((d == 0) ? ps_e : ps_c) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL wait_period_start_%0d: got timeout expected pulse", d);
        end
        idx = per_idx[d];
    endtask

    task automatic wr_e(input logic [3:0] d0, input logic [3:0] d1);
        duty_e[0] = d0; duty_e[1] = d1; duty_wr_e = 1'b1;
        @(negedge clk);
        #1;
        duty_wr_e = 1'b0;
    endtask

    task automatic wr_c(input logic [3:0] d0, input logic [3:0] d1);
        duty_c[0] = d0; duty_c[1] = d1; duty_wr_c = 1'b1;
        @(negedge clk);
        #1;
        duty_wr_c = 1'b0;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin : stim
        int  a, b, t;
        bit  seen;
        rst_n = 1'b0; duty_e = '0; duty_c = '0; duty_wr_e = 1'b0; duty_wr_c = 1'b0;

        // Reset held, then released between edges.
        repeat (3) @(negedge clk);
        chk("rst_hi_lo_e", int'({hi_e, lo_e}), 0);
        chk("rst_hi_lo_c", int'({hi_c, lo_c}), 0);
        chk("rst_ps_pend_e", int'({ps_e, pend_e}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_c1_lo_e", int'(lo_e), 0);
        chk("rel_c1_lo_dead0", int'(lo_z), 3);
        @(negedge clk);
        chk("rel_c2_lo_e", int'(lo_e), 3);
        chk("rel_c2_hi_e", int'(hi_e), 0);
        chk("rel_c2_lo_c", int'(lo_c), 3);

        // Edge mode: idle period, then ch0=5 / ch1=10.
        wait_ps(0, a);
        push_e(a, 0, 16, 0, 16, 0, 16);
        repeat (3) @(negedge clk);
        wr_e(4'd5, 4'd10);
        chk("pend_after_wr1", int'(pend_e), 1);

        wait_ps(0, t);
        chk("pend_clear_at_p2", int'(pend_e), 0);
        push_e(t, 3, 9, 8, 4, 5, 11);
        repeat (6) @(negedge clk);
        wr_e(4'd9, 4'd10);
        chk("pend_after_wr_cnt6", int'(pend_e), 1);
        repeat (8) @(negedge clk);
        chk("pend_held_cnt15", int'(pend_e), 1);

        wait_ps(0, t);
        chk("pend_clear_at_p3", int'(pend_e), 0);
        push_e(t, 7, 5, 8, 4, 9, 7);
        repeat (15) @(negedge clk);
        wr_e(4'd12, 4'd10);
        chk("bypass_wrap_ps", int'(ps_e), 1);
        chk("bypass_pend_zero", int'(pend_e), 0);
        t = per_idx[0];
        push_e(t, 10, 2, 8, 4, 12, 4);

        repeat (4) @(negedge clk);
        wr_e(4'd1, 4'd15);
        wait_ps(0, t);
        push_e(t, 0, 13, 13, 0, 1, 15);
        wait_ps(0, t);
        push_e(t, 0, 13, 13, 0, 1, 15);
        wait_ps(0, t);
        repeat (3) @(negedge clk);

        // Center mode: ch1=3, first applied period sees only the leading half of the pulse.
        wait_ps(1, b);
        push_c(b, 0, 30, 0, 30);
        repeat (5) @(negedge clk);
        wr_c(4'd0, 4'd3);
        chk("ctr_pend_after_wr", int'(pend_c), 1);
        wait_ps(1, t);
        chk("ctr_pend_clear", int'(pend_c), 0);
        push_c(t, 0, 30, 1, 23);
        wait_ps(1, t);
        push_c(t, 0, 30, 3, 23);
        wait_ps(1, t);
        repeat (3) @(negedge clk);

        chk("edge_queue_left", q_e.size(), 0);
        chk("ctr_queue_left", q_c.size(), 0);

        // Mid-period asynchronous reset while the high side is driving.
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (hi_e[1]) begin
                seen = 1'b1;
                break;
            end
        end
        chk("mid_rst_hi_seen", int'(seen), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_async_e", int'({hi_e, lo_e}), 0);
        chk("mid_rst_async_c", int'({hi_c, lo_c}), 0);
        repeat (2) @(negedge clk);
        chk("mid_rst_ps_pend", int'({ps_e, pend_e}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_c1_lo", int'(lo_e), 0);
        @(negedge clk);
        chk("mid_rel_c2_lo", int'(lo_e), 3);
        chk("mid_rel_c2_hi", int'(hi_e), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
